// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the multicycle CPU memory responder.
package cpu_mem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_e;
endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with per-byte write enables and registered read.
module mem_array
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++)
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end else begin
        rdata <= mem[addr];
      end
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Memory responder: one outstanding request, WAIT_CYCLES wait states, then response.
// Optional MEM_ALIGN_CHK_EN flags misaligned requests with rsp_err and suppresses them.
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                err_q;
  logic                ram_en;
  logic [WORD_W-1:0]   ram_rdata;
  logic                accept;
  logic                unused_addr;

  assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
  assign req_ready   = (state_q == IDLE);
  assign accept      = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ram_en  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        we_d    = req_we;
        addr_d  = req_addr[ADDR_W+1:2];
        be_d    = req_be;
        wdata_d = req_wdata;
        if (WAIT_CYCLES == 0) state_d = ACCESS;
        else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = ACCESS;
      end
      ACCESS: begin
        ram_en  = 1'b1;
        state_d = RESP;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef MEM_ALIGN_CHK_EN
  logic err_d;
  always_comb err_d = accept ? (|req_addr[1:0]) : err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign err_q = 1'b0;
`endif

  // Misaligned requests never touch the array; the RAM's read register is
  // only loaded in ACCESS, so it stays stable for the whole RESP phase.
  mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .en    (ram_en && !err_q),
    .we    (we_q),
    .be    (be_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : '0;
  assign rsp_err   = rsp_valid && err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_W=8, WAIT_CYCLES=2).
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        seen;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, obs, exp);
    end
  endtask

  // lat = edges from the accept edge to the first edge that samples rsp_valid high
  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] rdo, output logic erro, output int lato);
    int n;
    chk("req_ready_pre", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
    lato = 1; n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      lato++; n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    rdo = rsp_rdata; erro = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, rdo);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("post_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_rdata", rsp_rdata, 32'd0);
    chk("post_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_be = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd, er, lat);
    chk("wr_latency", 32'(lat), 32'd4);
    chk("wr_rdata", rd, 32'd0);
    chk("wr_err", {31'd0, er}, 32'd0);

    txn(1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat);
    chk("rd_latency", 32'(lat), 32'd4);
    chk("rd_word4", rd, 32'hDEADBEEF);
    chk("rd_err", {31'd0, er}, 32'd0);

    // 0x410 wraps to word 4; lanes 0 and 2 only
    txn(1'b1, 32'h410, 4'b0101, 32'h11223344, 0, rd, er, lat);
    txn(1'b0, 32'h10, 4'h0, 32'h0, 0, rd, er, lat);
    chk("rd_be_wrap", rd, 32'hDE22BE44);

    txn(1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF, 0, rd, er, lat);
    chk("be0_wr_lat", 32'(lat), 32'd4);
    txn(1'b0, 32'hFFFFFC10, 4'h0, 32'h0, 0, rd, er, lat);
    chk("rd_be0_highaddr", rd, 32'hDE22BE44);

    txn(1'b1, 32'h3FC, 4'hF, 32'hA5A55A5A, 0, rd, er, lat);
    txn(1'b0, 32'h3FC, 4'h0, 32'h0, 0, rd, er, lat);
    chk("rd_word255", rd, 32'hA5A55A5A);

`ifndef MEM_ALIGN_CHK_EN
    txn(1'b0, 32'h13, 4'h0, 32'h0, 0, rd, er, lat);
    chk("rd_lowbits_ign", rd, 32'hDE22BE44);
    chk("rd_lowbits_err", {31'd0, er}, 32'd0);
`endif

    // backpressure: response held 5 cycles, checked inside txn
    txn(1'b0, 32'h10, 4'h0, 32'h0, 5, rd, er, lat);
    chk("bp_first_rdata", rd, 32'hDE22BE44);

    // reset during WAIT of a write must leave the old word intact
    txn(1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 0, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    chk("mid_in_wait", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_no_rsp", {31'd0, seen}, 32'd0);
    txn(1'b0, 32'h20, 4'h0, 32'h0, 0, rd, er, lat);
    chk("mid_word_kept", rd, 32'hCAFEF00D);

`ifdef MEM_ALIGN_CHK_EN
    txn(1'b1, 32'h22, 4'hF, 32'h12345678, 0, rd, er, lat);
    chk("al_wr_err", {31'd0, er}, 32'd1);
    chk("al_wr_lat", 32'(lat), 32'd4);
    txn(1'b0, 32'h21, 4'h0, 32'h0, 0, rd, er, lat);
    chk("al_rd_err", {31'd0, er}, 32'd1);
    chk("al_rd_zero", rd, 32'd0);
    txn(1'b0, 32'h20, 4'h0, 32'h0, 0, rd, er, lat);
    chk("al_word_kept", rd, 32'hCAFEF00D);
    chk("al_ok_err", {31'd0, er}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
